// File: rtl/instr_fetch_unit.sv
// Fetch stage in front of the MIPS decode/execute datapath.
// Issues sequential word fetches to a handshaked instruction memory, buffers the returned
// words with their PCs in a small prefetch FIFO and hands {pc, instr} to decode.
// A redirect flushes the FIFO and marks every in-flight response as stale.
module instr_fetch_unit #(
   parameter int unsigned           ADDR_W   = 32,
   parameter int unsigned           DATA_W   = 32,
   parameter int unsigned           DEPTH    = 4,
   parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [DATA_W-1:0] if_instr,
   input  logic              id_ready
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]  DEPTH_LIMIT = (CNT_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  discard;
   logic [CNT_W-1:0]  count;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;

   logic [ADDR_W-1:0] pc_mem    [DEPTH];
   logic [DATA_W-1:0] instr_mem [DEPTH];

   logic [CNT_W:0]    in_use;
   logic [ADDR_W-1:0] redirect_aligned;
   logic              issue;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  issue_inc;
   logic [CNT_W-1:0]  rvalid_dec;
   logic [CNT_W-1:0]  push_inc;
   logic [CNT_W-1:0]  pop_dec;

   // Credit covers both words already buffered and words still in flight, so a returning
   // response always finds a free FIFO slot; a pop in the same cycle earns no credit.
   assign in_use           = {1'b0, outstanding} + {1'b0, count};
   assign imem_req         = rst_n && !redirect_valid && (in_use < DEPTH_LIMIT);
   assign imem_addr        = fetch_pc;
   assign redirect_aligned = redirect_pc & ALIGN_MASK;

   assign issue = imem_req && imem_gnt;
   assign push  = imem_rvalid && (discard == '0) && !redirect_valid;
   assign pop   = if_valid && id_ready && !redirect_valid;

   assign issue_inc  = CNT_W'(issue);
   assign rvalid_dec = CNT_W'(imem_rvalid);
   assign push_inc   = CNT_W'(push);
   assign pop_dec    = CNT_W'(pop);

   // Decode sees only registered FIFO state; an empty FIFO presents zeros.
   assign if_valid = (count != '0);
   assign if_pc    = if_valid ? pc_mem[head]    : '0;
   assign if_instr = if_valid ? instr_mem[head] : '0;

   // Fetch/response PCs, credit counters and FIFO pointers; redirect overrides everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_aligned;
         resp_pc     <= redirect_aligned;
         outstanding <= outstanding - rvalid_dec;
         discard     <= outstanding - rvalid_dec;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
      end else begin
         if (issue) begin
            fetch_pc <= fetch_pc + PC_STEP;
         end
         outstanding <= outstanding + issue_inc - rvalid_dec;
         if (imem_rvalid && (discard != '0)) begin
            discard <= discard - 1'b1;
         end
         if (push) begin
            tail    <= tail + 1'b1;
            resp_pc <= resp_pc + PC_STEP;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         count <= count + push_inc - pop_dec;
      end
   end

   // FIFO payload storage; contents are only visible through the count-gated head read.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[tail]    <= resp_pc;
         instr_mem[tail] <= imem_rdata;
      end
   end

   // A response with nothing in flight means the memory side broke the handshake contract.
   rvalid_needs_outstanding: assert property (
      @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != '0)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// An in-order instruction memory with random grant/latency drives the DUT, and a queue-based
// reference model (fetch epochs, expected delivery queue) predicts every visible output.
module tb_instr_fetch_unit;

   localparam int          ADDR_W   = 32;
   localparam int          DATA_W   = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic              clk;
   logic              rst_n;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [DATA_W-1:0] imem_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              if_valid;
   logic [ADDR_W-1:0] if_pc;
   logic [DATA_W-1:0] if_instr;
   logic              id_ready;

   instr_fetch_unit #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .id_ready       (id_ready)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ready;
      int          epoch;
   } mem_req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   typedef struct {
      logic [31:0] redirect_pc;
      logic [31:0] exp_addr;
      logic [31:0] exp_next;
   } vec_t;

   mem_req_t    mem_q[$];
   entry_t      model_q[$];
   logic [31:0] log_q[$];
   vec_t        vecs[4];

   int          inflight;
   int          epoch;
   int          cyc;
   int          grants;
   int          first_gnt_cyc;
   int          first_valid_cyc;
   logic [31:0] model_fetch_pc;
   logic [31:0] last_addr;
   logic        last_req;

   int          gnt_pct;
   int          rdy_pct;
   int          lat_min;
   int          lat_max;
   bit          redir;
   logic [31:0] redir_pc;

   int          checks;
   int          passes;

   // Single comparison: counts it and reports any difference
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Compares one entry of the delivered-PC log, treating a missing entry as a failure
   task automatic checkLog(input string name, input int idx, input logic [31:0] exp);
      if (log_q.size() > idx) begin
         check(name, {32'h0, log_q[idx]}, {32'h0, exp});
      end else begin
         checks++;
         $display("[TB] FAIL %s: only %0d instructions delivered, required pc %h at index %0d",
                  name, log_q.size(), exp, idx);
      end
   endtask

   // Compares the DUT outputs of the current cycle with the reference model
   task automatic checkOutput();
      logic exp_req;
      exp_req = !redir && ((inflight + model_q.size()) < DEPTH);
      check("imem_req", {63'h0, imem_req}, {63'h0, exp_req});
      if (exp_req) check("imem_addr", {32'h0, imem_addr}, {32'h0, model_fetch_pc});
      check("if_valid", {63'h0, if_valid}, {63'h0, model_q.size() != 0});
      if (model_q.size() != 0) begin
         check("if_pc", {32'h0, if_pc}, {32'h0, model_q[0].pc});
         check("if_instr", {32'h0, if_instr}, {32'h0, model_q[0].instr});
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, check, then advance the model at the rising edge
   task automatic applyStimulus();
      logic     issue;
      logic     pop;
      logic     rv;
      mem_req_t m;
      int       lat;
      @(negedge clk);
      imem_gnt       = ($urandom_range(99) < gnt_pct);
      id_ready       = ($urandom_range(99) < rdy_pct);
      redirect_valid = redir;
      redirect_pc    = redir_pc;
      if (mem_q.size() != 0 && mem_q[0].ready <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_q[0].addr;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
      checkOutput();
      issue     = imem_req && imem_gnt;
      pop       = if_valid && id_ready && !redir;
      rv        = imem_rvalid;
      last_addr = imem_addr;
      last_req  = imem_req;
      if (issue && first_gnt_cyc < 0) first_gnt_cyc = cyc;
      if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pop) log_q.push_back(if_pc);
      @(posedge clk);
      m = '{addr: 32'h0, ready: 0, epoch: -1};
      if (rv && mem_q.size() != 0) begin
         m = mem_q.pop_front();
         inflight--;
      end
      if (redir) begin
         model_q.delete();
         epoch++;
         model_fetch_pc = redir_pc & 32'hFFFF_FFFC;
      end else begin
         if (pop && model_q.size() != 0) void'(model_q.pop_front());
         if (rv && m.epoch == epoch) model_q.push_back('{pc: m.addr, instr: m.addr});
         if (issue) begin
            lat = $urandom_range(lat_max, lat_min);
            mem_q.push_back('{addr: model_fetch_pc, ready: cyc + lat, epoch: epoch});
            inflight++;
            grants++;
            model_fetch_pc = model_fetch_pc + 32'd4;
         end
      end
      cyc++;
   endtask

   // Asynchronous reset of DUT and memory; outputs must drop in the same cycle
   task automatic doReset();
      @(negedge clk);
      rst_n          = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      id_ready       = 1'b0;
      redir          = 1'b0;
      #1;
      check("rst imem_req", {63'h0, imem_req}, 64'h0);
      check("rst if_valid", {63'h0, if_valid}, 64'h0);
      check("rst if_pc", {32'h0, if_pc}, 64'h0);
      check("rst if_instr", {32'h0, if_instr}, 64'h0);
      mem_q.delete();
      model_q.delete();
      log_q.delete();
      inflight        = 0;
      epoch++;
      cyc             = 0;
      grants          = 0;
      first_gnt_cyc   = -1;
      first_valid_cyc = -1;
      model_fetch_pc  = RESET_PC;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Test sequence
   initial begin
      int delivered_target;
      int budget;

      vecs[0] = '{redirect_pc: 32'h0000_0100, exp_addr: 32'h0000_0100, exp_next: 32'h0000_0104};
      vecs[1] = '{redirect_pc: 32'h0000_0203, exp_addr: 32'h0000_0200, exp_next: 32'h0000_0204};
      vecs[2] = '{redirect_pc: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
      vecs[3] = '{redirect_pc: 32'h0000_0007, exp_addr: 32'h0000_0004, exp_next: 32'h0000_0008};

      checks = 0; passes = 0; epoch = 0; cyc = 0;
      rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
      redir = 1'b0; redir_pc = '0;
      gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;

      // Streaming with a single-cycle memory
      doReset();
      gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
      repeat (12) applyStimulus();
      check("gnt to if_valid latency", 64'(first_valid_cyc - first_gnt_cyc), 64'd2);
      checkLog("stream pc0", 0, 32'h0);
      checkLog("stream pc1", 1, 32'h4);
      checkLog("stream pc2", 2, 32'h8);
      checkLog("stream pc3", 3, 32'hC);

      // Decode stalled: credit stops at DEPTH, then drains in order
      doReset();
      rdy_pct = 0;
      repeat (10) applyStimulus();
      check("stall grants", 64'(grants), 64'(DEPTH));
      check("stall if_valid", {63'h0, if_valid}, 64'h1);
      rdy_pct = 100;
      repeat (10) applyStimulus();
      checkLog("drain pc0", 0, 32'h0);
      checkLog("drain pc1", 1, 32'h4);
      checkLog("drain pc2", 2, 32'h8);
      checkLog("drain pc3", 3, 32'hC);
      check("req resumes", {63'h0, grants > DEPTH}, 64'h1);

      // Redirect with three requests in flight on a 3-cycle memory
      doReset();
      lat_min = 3; lat_max = 3;
      repeat (3) applyStimulus();
      check("three in flight", 64'(inflight), 64'd3);
      redir = 1'b1; redir_pc = 32'h0000_0100;
      applyStimulus();
      redir = 1'b0;
      log_q.delete();
      applyStimulus();
      check("redirect fetch addr", {32'h0, last_addr}, 64'h100);
      repeat (14) applyStimulus();
      checkLog("after redirect pc0", 0, 32'h100);
      checkLog("after redirect pc1", 1, 32'h104);

      // Redirect coincident with a response and a pop at two buffered entries
      doReset();
      lat_min = 1; lat_max = 1; rdy_pct = 0;
      repeat (3) applyStimulus();
      redir = 1'b1; redir_pc = 32'h0000_0203; rdy_pct = 100;
      applyStimulus();
      redir = 1'b0;
      log_q.delete();
      repeat (10) applyStimulus();
      checkLog("coincident pc0", 0, 32'h200);
      checkLog("coincident pc1", 1, 32'h204);

      // Table of redirect targets: alignment and address wrap
      doReset();
      for (int i = 0; i < 4; i++) begin
         repeat (2) applyStimulus();
         redir = 1'b1; redir_pc = vecs[i].redirect_pc;
         applyStimulus();
         redir = 1'b0;
         log_q.delete();
         applyStimulus();
         check($sformatf("vec%0d fetch addr", i), {32'h0, last_addr}, {32'h0, vecs[i].exp_addr});
         repeat (8) applyStimulus();
         checkLog($sformatf("vec%0d pc0", i), 0, vecs[i].exp_addr);
         checkLog($sformatf("vec%0d pc1", i), 1, vecs[i].exp_next);
      end

      // Random grant, latency, stall and redirect traffic
      doReset();
      gnt_pct = 60; rdy_pct = 70; lat_min = 1; lat_max = 4;
      delivered_target = 1000;
      budget = 20000;
      while (log_q.size() < delivered_target && budget > 0) begin
         redir    = ($urandom_range(99) < 2);
         redir_pc = $urandom;
         applyStimulus();
         budget--;
      end
      redir = 1'b0;
      check("random delivered", {63'h0, log_q.size() >= delivered_target}, 64'h1);

      // Reset in the middle of traffic, then restart from RESET_PC
      repeat (30) applyStimulus();
      doReset();
      gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
      applyStimulus();
      check("restart req", {63'h0, last_req}, 64'h1);
      check("restart addr", {32'h0, last_addr}, {32'h0, RESET_PC});
      repeat (6) applyStimulus();
      checkLog("restart pc0", 0, RESET_PC);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
